// File: rtl/xif_sig_pkg.sv
// Shared encodings and types for the signature coprocessor on the CV-X-IF.
package xif_sig_pkg;

    localparam logic [6:0] OPC_SIG   = 7'h0B;
    localparam logic [2:0] F3_SIGACC = 3'b000;
    localparam logic [2:0] F3_SIGRD  = 3'b001;
    localparam logic [2:0] F3_SIGCLR = 3'b010;

    // Queue payload; the id is kept beside it because its width is a parameter
    typedef struct packed {
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [31:0] rs1;
    } sig_op_t;

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    function automatic logic [31:0] sig_rotxor(input logic [31:0] sig, input logic [31:0] rs1);
        return {sig[30:0], sig[31]} ^ rs1;
    endfunction

endpackage

// File: rtl/xif_sig_coproc_if.sv
// Issue, commit and result channels between the CPU and the signature coprocessor.
interface xif_sig_coproc_if #(
    parameter int X_ID_WIDTH = 4
);
    logic                  issue_valid_i;
    logic                  issue_ready_o;
    logic [31:0]           issue_instr_i;
    logic [X_ID_WIDTH-1:0] issue_id_i;
    logic [31:0]           issue_rs0_i;
    logic [1:0]            issue_rs_valid_i;
    logic                  issue_accept_o;
    logic                  issue_writeback_o;
    logic                  commit_valid_i;
    logic [X_ID_WIDTH-1:0] commit_id_i;
    logic                  commit_kill_i;
    logic                  result_valid_o;
    logic                  result_ready_i;
    logic [X_ID_WIDTH-1:0] result_id_o;
    logic [31:0]           result_data_o;
    logic [4:0]            result_rd_o;
    logic                  result_we_o;

    modport master (
        output issue_valid_i, issue_instr_i, issue_id_i, issue_rs0_i, issue_rs_valid_i,
        output commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
        input  issue_ready_o, issue_accept_o, issue_writeback_o,
        input  result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o
    );

    modport slave (
        input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs0_i, issue_rs_valid_i,
        input  commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
        output issue_ready_o, issue_accept_o, issue_writeback_o,
        output result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o
    );
endinterface

// File: rtl/xif_sig_queue.sv
// In-order instruction FIFO whose entries collect commit/kill decisions by id match.
module xif_sig_queue
    import xif_sig_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ID_W  = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic [ID_W-1:0] push_id_i,
    input  sig_op_t         push_op_i,
    input  logic            pop_i,
    input  logic            cmt_valid_i,
    input  logic [ID_W-1:0] cmt_id_i,
    input  logic            cmt_kill_i,
    output logic            full_o,
    output logic            head_vld_o,
    output logic            head_cmt_o,
    output logic            head_kill_o,
    output logic [ID_W-1:0] head_id_o,
    output sig_op_t         head_op_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt;
    logic [ID_W-1:0]   id_q [DEPTH];
    logic [ID_W-1:0]   id_d [DEPTH];
    sig_op_t           op_q [DEPTH];
    sig_op_t           op_d [DEPTH];
    logic [DEPTH-1:0]  cmt_q, cmt_d, kill_q, kill_d, vld;
    logic [AW-1:0]     hidx, widx;
    logic              head_hit, push_hit;

    assign cnt  = wr_ptr_q - rd_ptr_q;
    assign hidx = rd_ptr_q[AW-1:0];
    assign widx = wr_ptr_q[AW-1:0];

    // An entry is live when its distance from the read pointer is below the fill count
    for (genvar g = 0; g < DEPTH; g++) begin : g_vld
        logic [AW-1:0] offs;
        assign offs   = AW'(g) - hidx;
        assign vld[g] = {1'b0, offs} < cnt;
    end

    assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (widx == hidx);
    assign head_vld_o = (cnt != '0);
    assign head_id_o  = id_q[hidx];
    assign head_op_o  = op_q[hidx];
    // Bypass a same-cycle commit on the head so results can start one cycle earlier
    assign head_hit    = cmt_valid_i && (cmt_id_i == id_q[hidx]);
    assign head_cmt_o  = cmt_q[hidx] | head_hit;
    assign head_kill_o = head_hit ? cmt_kill_i : kill_q[hidx];
    assign push_hit    = cmt_valid_i && (cmt_id_i == push_id_i);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        id_d     = id_q;
        op_d     = op_q;
        cmt_d    = cmt_q;
        kill_d   = kill_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && cmt_valid_i && (id_q[i] == cmt_id_i)) begin
                cmt_d[i]  = 1'b1;
                kill_d[i] = cmt_kill_i;
            end
        end
        if (push_i) begin
            id_d[widx]   = push_id_i;
            op_d[widx]   = push_op_i;
            cmt_d[widx]  = push_hit;
            kill_d[widx] = push_hit && cmt_kill_i;
            wr_ptr_d     = wr_ptr_q + 1'b1;
        end
        if (pop_i) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        id_q <= id_d;
        op_q <= op_d;
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cmt_q    <= '0;
            kill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cmt_q    <= cmt_d;
            kill_q   <= kill_d;
        end
    end

endmodule

// File: rtl/xif_sig_coproc.sv
// Signature coprocessor: decodes SIGACC/SIGRD/SIGCLR, queues them, executes in order after commit.
module xif_sig_coproc
    import xif_sig_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int X_ID_WIDTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    xif_sig_coproc_if.slave xif
);
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic                  is_sig, issue_ready, push, pop, unused_bits;
    logic                  q_full, head_vld, head_cmt, head_kill;
    logic [X_ID_WIDTH-1:0] head_id;
    sig_op_t               head_op, push_op;
    state_e                state_q, state_d;
    logic [31:0]           sig_q, sig_d, res_data_q, res_data_d, res_sig_q, res_sig_d;
    logic [X_ID_WIDTH-1:0] res_id_q, res_id_d;
    logic [4:0]            res_rd_q, res_rd_d;
    logic                  res_we_q, res_we_d;

    assign opcode      = xif.issue_instr_i[6:0];
    assign funct3      = xif.issue_instr_i[14:12];
    assign unused_bits = ^{xif.issue_instr_i[31:15], xif.issue_rs_valid_i[1]};
    assign is_sig      = (opcode == OPC_SIG) &&
                         (funct3 == F3_SIGACC || funct3 == F3_SIGRD || funct3 == F3_SIGCLR);

    // Foreign instructions are never stalled; ours wait for space and, for SIGACC, rs1
    assign issue_ready = !is_sig ||
                         (!q_full && (funct3 != F3_SIGACC || xif.issue_rs_valid_i[0]));
    assign push        = xif.issue_valid_i && issue_ready && is_sig;
    assign push_op     = '{funct3: funct3, rd: xif.issue_instr_i[11:7], rs1: xif.issue_rs0_i};

    assign xif.issue_ready_o     = issue_ready;
    assign xif.issue_accept_o    = is_sig;
    assign xif.issue_writeback_o = is_sig && (funct3 != F3_SIGCLR);

    xif_sig_queue #(.DEPTH(DEPTH), .ID_W(X_ID_WIDTH)) u_queue (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_id_i   (xif.issue_id_i),
        .push_op_i   (push_op),
        .pop_i       (pop),
        .cmt_valid_i (xif.commit_valid_i),
        .cmt_id_i    (xif.commit_id_i),
        .cmt_kill_i  (xif.commit_kill_i),
        .full_o      (q_full),
        .head_vld_o  (head_vld),
        .head_cmt_o  (head_cmt),
        .head_kill_o (head_kill),
        .head_id_o   (head_id),
        .head_op_o   (head_op)
    );

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        sig_d      = sig_q;
        res_id_d   = res_id_q;
        res_data_d = res_data_q;
        res_rd_d   = res_rd_q;
        res_we_d   = res_we_q;
        res_sig_d  = res_sig_q;
        case (state_q)
            ST_WAIT: begin
                if (head_vld && head_cmt) begin
                    if (head_kill) begin
                        pop = 1'b1;
                    end else begin
                        res_id_d = head_id;
                        res_rd_d = head_op.rd;
                        case (head_op.funct3)
                            F3_SIGACC: begin
                                res_sig_d  = sig_rotxor(sig_q, head_op.rs1);
                                res_data_d = sig_rotxor(sig_q, head_op.rs1);
                                res_we_d   = 1'b1;
                            end
                            F3_SIGRD: begin
                                res_sig_d  = sig_q;
                                res_data_d = sig_q;
                                res_we_d   = 1'b1;
                            end
                            default: begin
                                res_sig_d  = '0;
                                res_data_d = '0;
                                res_we_d   = 1'b0;
                            end
                        endcase
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                // The signature only moves once the CPU has taken the result
                if (xif.result_ready_i) begin
                    sig_d   = res_sig_q;
                    pop     = 1'b1;
                    state_d = ST_WAIT;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_WAIT;
            sig_q      <= '0;
            res_id_q   <= '0;
            res_data_q <= '0;
            res_rd_q   <= '0;
            res_we_q   <= 1'b0;
            res_sig_q  <= '0;
        end else begin
            state_q    <= state_d;
            sig_q      <= sig_d;
            res_id_q   <= res_id_d;
            res_data_q <= res_data_d;
            res_rd_q   <= res_rd_d;
            res_we_q   <= res_we_d;
            res_sig_q  <= res_sig_d;
        end
    end

    assign xif.result_valid_o = (state_q == ST_RESP);
    assign xif.result_id_o    = res_id_q;
    assign xif.result_data_o  = res_data_q;
    assign xif.result_rd_o    = res_rd_q;
    assign xif.result_we_o    = res_we_q;

endmodule

// File: tb/tb_xif_sig_coproc.sv
// Directed bench for xif_sig_coproc: decode, commit/kill, back-pressure, full queue, reset.
module tb_xif_sig_coproc;
    import xif_sig_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    xif_sig_coproc_if #(.X_ID_WIDTH(4)) x ();
    xif_sig_coproc #(.DEPTH(4), .X_ID_WIDTH(4)) dut (.clk_i(clk), .rst_i(rst), .xif(x.slave));

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
        return {17'd0, f3, rd, opc};
    endfunction

    task automatic drive_issue(input logic [31:0] instr, input logic [3:0] id,
                               input logic [31:0] rs1, input logic [1:0] rsv);
        x.issue_valid_i    = 1'b1;
        x.issue_instr_i    = instr;
        x.issue_id_i       = id;
        x.issue_rs0_i      = rs1;
        x.issue_rs_valid_i = rsv;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [3:0] id, input logic [31:0] rs1);
        @(negedge clk);
        drive_issue(instr, id, rs1, 2'b01);
        @(posedge clk); #1;
        x.issue_valid_i = 1'b0;
    endtask

    task automatic commit(input logic [3:0] id, input logic kill);
        @(negedge clk);
        x.commit_valid_i = 1'b1;
        x.commit_id_i    = id;
        x.commit_kill_i  = kill;
        @(posedge clk); #1;
        x.commit_valid_i = 1'b0;
    endtask

    task automatic wait_result(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (x.result_valid_o === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic take();
        @(negedge clk);
        x.result_ready_i = 1'b1;
        @(posedge clk); #1;
        x.result_ready_i = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] instr, input logic [3:0] id, input logic [31:0] rs1,
                          output logic [31:0] data, output logic [3:0] rid);
        bit found;
        issue(instr, id, rs1);
        commit(id, 1'b0);
        wait_result(found);
        data = x.result_data_o;
        rid  = x.result_id_o;
        n_chk++;
        if (found !== 1'b1) begin
            n_err++;
            $display("FAIL run_op_timeout id=%0d: result_valid never rose, required 1", id);
        end else begin
            take();
        end
    endtask

    task automatic test_reset();
        x.issue_valid_i = 0; x.issue_instr_i = mk(F3_SIGRD, 5'd1, OPC_SIG); x.issue_id_i = 0;
        x.issue_rs0_i = 0; x.issue_rs_valid_i = 0; x.commit_valid_i = 0; x.commit_id_i = 0;
        x.commit_kill_i = 0; x.result_ready_i = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        n_chk++; if (x.issue_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", x.issue_ready_o); end
        n_chk++; if (x.result_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", x.result_valid_o); end
        n_chk++; if ({x.result_id_o, x.result_data_o, x.result_rd_o, x.result_we_o} !== '0) begin
            n_err++; $display("FAIL reset_result got id=%h data=%h rd=%h we=%b want all 0",
                              x.result_id_o, x.result_data_o, x.result_rd_o, x.result_we_o);
        end
    endtask

    task automatic test_sigacc();
        @(negedge clk);
        drive_issue(mk(F3_SIGACC, 5'd5, OPC_SIG), 4'd3, 32'h1, 2'b01); #1;
        n_chk++; if (x.issue_accept_o !== 1'b1) begin n_err++; $display("FAIL acc_accept got %b want 1", x.issue_accept_o); end
        n_chk++; if (x.issue_writeback_o !== 1'b1) begin n_err++; $display("FAIL acc_wb got %b want 1", x.issue_writeback_o); end
        n_chk++; if (x.issue_ready_o !== 1'b1) begin n_err++; $display("FAIL acc_ready got %b want 1", x.issue_ready_o); end
        @(posedge clk); #1;
        x.issue_valid_i = 1'b0;
        commit(4'd3, 1'b0);
        n_chk++; if (x.result_valid_o !== 1'b1) begin n_err++; $display("FAIL acc_latency valid got %b want 1", x.result_valid_o); end
        n_chk++; if (x.result_id_o !== 4'd3 || x.result_data_o !== 32'h1 || x.result_we_o !== 1'b1 || x.result_rd_o !== 5'd5) begin
            n_err++; $display("FAIL acc_result got id=%0d data=%h we=%b rd=%0d want 3 00000001 1 5",
                              x.result_id_o, x.result_data_o, x.result_we_o, x.result_rd_o);
        end
        take();
        n_chk++; if (x.result_valid_o !== 1'b0) begin n_err++; $display("FAIL acc_drop got %b want 0", x.result_valid_o); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d; logic [3:0] r;
        run_op(mk(F3_SIGCLR, 5'd0, OPC_SIG), 4'd4, 32'h0, d, r);
        n_chk++; if (d !== 32'h0) begin n_err++; $display("FAIL bp_clr got %h want 00000000", d); end
        run_op(mk(F3_SIGACC, 5'd1, OPC_SIG), 4'd5, 32'h8000_0000, d, r);
        n_chk++; if (d !== 32'h8000_0000) begin n_err++; $display("FAIL bp_setup got %h want 80000000", d); end
        issue(mk(F3_SIGACC, 5'd2, OPC_SIG), 4'd6, 32'h10);
        commit(4'd6, 1'b0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_chk++; if (x.result_valid_o !== 1'b1 || x.result_data_o !== 32'h11) begin
                n_err++; $display("FAIL bp_hold cyc=%0d got valid=%b data=%h want 1 00000011", c, x.result_valid_o, x.result_data_o);
            end
            if (c == 5) x.result_ready_i = 1'b1;
            @(posedge clk); #1;
        end
        x.result_ready_i = 1'b0;
        n_chk++; if (x.result_valid_o !== 1'b0) begin n_err++; $display("FAIL bp_release got %b want 0", x.result_valid_o); end
        run_op(mk(F3_SIGRD, 5'd3, OPC_SIG), 4'd7, 32'h0, d, r);
        n_chk++; if (d !== 32'h11) begin n_err++; $display("FAIL bp_sig got %h want 00000011", d); end
    endtask

    task automatic test_kill();
        logic [31:0] d; logic [3:0] r; bit found; bit extra;
        run_op(mk(F3_SIGCLR, 5'd0, OPC_SIG), 4'd1, 32'h0, d, r);
        run_op(mk(F3_SIGACC, 5'd1, OPC_SIG), 4'd2, 32'hABCD_0000, d, r);
        n_chk++; if (d !== 32'hABCD_0000) begin n_err++; $display("FAIL kill_setup got %h want abcd0000", d); end
        issue(mk(F3_SIGCLR, 5'd4, OPC_SIG), 4'd1, 32'h0);
        issue(mk(F3_SIGRD, 5'd6, OPC_SIG), 4'd2, 32'h0);
        commit(4'd1, 1'b1);
        n_chk++; if (x.result_valid_o !== 1'b0) begin n_err++; $display("FAIL kill_noresult got %b want 0", x.result_valid_o); end
        commit(4'd2, 1'b0);
        wait_result(found);
        n_chk++; if (found !== 1'b1 || x.result_id_o !== 4'd2 || x.result_data_o !== 32'hABCD_0000 || x.result_we_o !== 1'b1) begin
            n_err++; $display("FAIL kill_result got found=%b id=%0d data=%h we=%b want 1 2 abcd0000 1",
                              found, x.result_id_o, x.result_data_o, x.result_we_o);
        end
        take();
        extra = 1'b0;
        repeat (4) begin @(negedge clk); if (x.result_valid_o !== 1'b0) extra = 1'b1; end
        n_chk++; if (extra !== 1'b0) begin n_err++; $display("FAIL kill_single got extra result, want none"); end
    endtask

    task automatic test_queue_full();
        for (int i = 0; i < 4; i++) issue(mk(F3_SIGRD, 5'(8 + i), OPC_SIG), 4'(8 + i), 32'h0);
        @(negedge clk);
        drive_issue(mk(F3_SIGRD, 5'd12, OPC_SIG), 4'd12, 32'h0, 2'b01); #1;
        n_chk++; if (x.issue_ready_o !== 1'b0 || x.issue_accept_o !== 1'b1) begin
            n_err++; $display("FAIL full_ready got ready=%b accept=%b want 0 1", x.issue_ready_o, x.issue_accept_o);
        end
        x.issue_instr_i = mk(3'b000, 5'd1, 7'h33); #1;
        n_chk++; if (x.issue_ready_o !== 1'b1 || x.issue_accept_o !== 1'b0 || x.issue_writeback_o !== 1'b0) begin
            n_err++; $display("FAIL full_foreign got ready=%b accept=%b wb=%b want 1 0 0",
                              x.issue_ready_o, x.issue_accept_o, x.issue_writeback_o);
        end
        @(posedge clk); #1;
        x.issue_instr_i = mk(F3_SIGRD, 5'd12, OPC_SIG);
        x.commit_valid_i = 1'b1; x.commit_id_i = 4'd8; x.commit_kill_i = 1'b0;
        @(posedge clk); #1;
        x.commit_valid_i = 1'b0;
        n_chk++; if (x.result_valid_o !== 1'b1 || x.result_id_o !== 4'd8 || x.result_data_o !== 32'hABCD_0000) begin
            n_err++; $display("FAIL full_head got valid=%b id=%0d data=%h want 1 8 abcd0000",
                              x.result_valid_o, x.result_id_o, x.result_data_o);
        end
        @(negedge clk); x.result_ready_i = 1'b1; #1;
        n_chk++; if (x.issue_ready_o !== 1'b0) begin n_err++; $display("FAIL full_pop_same_cycle got ready=%b want 0", x.issue_ready_o); end
        @(posedge clk); #1; x.result_ready_i = 1'b0;
        @(negedge clk);
        n_chk++; if (x.issue_ready_o !== 1'b1) begin n_err++; $display("FAIL full_after_pop got ready=%b want 1", x.issue_ready_o); end
        @(posedge clk); #1; x.issue_valid_i = 1'b0;
        for (int i = 9; i < 13; i++) commit(4'(i), 1'b1);
        @(negedge clk);
        n_chk++; if (x.result_valid_o !== 1'b0) begin n_err++; $display("FAIL full_drain got valid=%b want 0", x.result_valid_o); end
    endtask

    task automatic test_operand_wait();
        @(negedge clk);
        drive_issue(mk(F3_SIGACC, 5'd1, OPC_SIG), 4'd13, 32'h5, 2'b00); #1;
        n_chk++; if (x.issue_ready_o !== 1'b0 || x.issue_accept_o !== 1'b1) begin
            n_err++; $display("FAIL opw_stall got ready=%b accept=%b want 0 1", x.issue_ready_o, x.issue_accept_o);
        end
        @(negedge clk);
        x.issue_rs_valid_i = 2'b10; #1;
        n_chk++; if (x.issue_ready_o !== 1'b0) begin n_err++; $display("FAIL opw_rs2only got ready=%b want 0", x.issue_ready_o); end
        x.issue_rs_valid_i = 2'b01; #1;
        n_chk++; if (x.issue_ready_o !== 1'b1) begin n_err++; $display("FAIL opw_go got ready=%b want 1", x.issue_ready_o); end
        @(posedge clk); #1; x.issue_valid_i = 1'b0;
        commit(4'd13, 1'b1);
    endtask

    task automatic test_back_to_back();
        issue(mk(F3_SIGACC, 5'd1, OPC_SIG), 4'd1, 32'h1);
        issue(mk(F3_SIGRD, 5'd2, OPC_SIG), 4'd2, 32'h0);
        @(negedge clk); x.result_ready_i = 1'b1;
        commit(4'd1, 1'b0);
        n_chk++; if (x.result_valid_o !== 1'b1 || x.result_id_o !== 4'd1 || x.result_data_o !== 32'h579A_0000) begin
            n_err++; $display("FAIL b2b_first got valid=%b id=%0d data=%h want 1 1 579a0000",
                              x.result_valid_o, x.result_id_o, x.result_data_o);
        end
        commit(4'd2, 1'b0);
        n_chk++; if (x.result_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_gap got valid=%b want 0", x.result_valid_o); end
        @(posedge clk); #1;
        n_chk++; if (x.result_valid_o !== 1'b1 || x.result_id_o !== 4'd2 || x.result_data_o !== 32'h579A_0000) begin
            n_err++; $display("FAIL b2b_second got valid=%b id=%0d data=%h want 1 2 579a0000",
                              x.result_valid_o, x.result_id_o, x.result_data_o);
        end
        @(posedge clk); #1;
        x.result_ready_i = 1'b0;
        n_chk++; if (x.result_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_end got valid=%b want 0", x.result_valid_o); end
    endtask

    task automatic test_reset_in_resp();
        logic [31:0] d; logic [3:0] r;
        issue(mk(F3_SIGRD, 5'd1, OPC_SIG), 4'd5, 32'h0);
        issue(mk(F3_SIGRD, 5'd2, OPC_SIG), 4'd7, 32'h0);
        commit(4'd5, 1'b0);
        n_chk++; if (x.result_valid_o !== 1'b1) begin n_err++; $display("FAIL rst_resp_pre got valid=%b want 1", x.result_valid_o); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (x.result_valid_o !== 1'b0 || x.result_data_o !== 32'h0) begin
            n_err++; $display("FAIL rst_resp_drop got valid=%b data=%h want 0 00000000", x.result_valid_o, x.result_data_o);
        end
        @(negedge clk); rst = 1'b0;
        run_op(mk(F3_SIGRD, 5'd3, OPC_SIG), 4'd6, 32'h0, d, r);
        n_chk++; if (r !== 4'd6 || d !== 32'h0) begin
            n_err++; $display("FAIL rst_resp_empty got id=%0d data=%h want 6 00000000", r, d);
        end
    endtask

    initial begin
        test_reset();
        test_sigacc();
        test_backpressure();
        test_kill();
        test_queue_full();
        test_operand_wait();
        test_back_to_back();
        test_reset_in_resp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
